keypad_scanner: RTL and testbench

Parametrised matrix-keypad scanner. It drives one column low at a time, samples the active-low row lines, debounces the result over whole scan frames, and reports a single debounced key as a binary code with press and release strobes. It sits between the keypad pins and the display/controller logic, and is the self-scanning, debounced, size-generic successor to the fixed 4x4 key encoder.

---
 rtl/keypad_if.sv | 33 +++
 rtl/keypad_scanner.sv | 156 +++++++++++++++
 tb/tb_keypad_scanner.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/keypad_if.sv
// keypad_if: pin-side and key-event signals of the matrix keypad scanner.
//   Rows       keypad row lines, active low (driven by the keypad)
//   Columns    one-hot-low column drive
//   KeyCode    code of the last accepted key (row*NUM_COLS + col)
//   KeyValid   accepted state is a single key
//   KeyPress   one-cycle strobe, new single key accepted
//   KeyRelease one-cycle strobe, accepted single key left
//   MultiKey   accepted state is "more than one contact"
// master = scanner side, slave = keypad/consumer side.
interface keypad_if #(
    parameter int NUM_ROWS = 4,
    parameter int NUM_COLS = 4
);
    localparam int CODE_W = (NUM_ROWS * NUM_COLS > 1) ? $clog2(NUM_ROWS * NUM_COLS) : 1;

    logic [NUM_ROWS-1:0] Rows;
    logic [NUM_COLS-1:0] Columns;
    logic [CODE_W-1:0]   KeyCode;
    logic                KeyValid;
    logic                KeyPress;
    logic                KeyRelease;
    logic                MultiKey;

    modport master (
        input  Rows,
        output Columns, KeyCode, KeyValid, KeyPress, KeyRelease, MultiKey
    );

    modport slave (
        output Rows,
        input  Columns, KeyCode, KeyValid, KeyPress, KeyRelease, MultiKey
    );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: self-scanning, debounced matrix keypad encoder.
// Drives one column low per dwell of SCAN_DIV cycles, samples the
// synchronised rows at the end of each dwell, condenses each full sweep
// into a frame candidate (NONE / KEY(code) / MULTI) and accepts a
// candidate once it has been seen on DEBOUNCE consecutive frames.
// Ports:
//   Clock  system clock, rising edge
//   Reset  asynchronous, active high
//   kp     keypad_if.master (Rows in; Columns, KeyCode, KeyValid,
//          KeyPress, KeyRelease, MultiKey out, all registered)
module keypad_scanner #(
    parameter int NUM_ROWS = 4,
    parameter int NUM_COLS = 4,
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic     Clock,
    input  logic     Reset,
    keypad_if.master kp
);
    localparam int CODE_W = (NUM_ROWS * NUM_COLS > 1) ? $clog2(NUM_ROWS * NUM_COLS) : 1;
    localparam int ROW_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int COL_W  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int CNT_W  = $clog2(SCAN_DIV);
    localparam int STB_W  = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {S_NONE, S_KEY, S_MULTI} kstate_t;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [NUM_ROWS-1:0] rows_s1, rows_s2;
    logic [1:0]          nacc_q, nacc_d;
    logic [CODE_W-1:0]   first_q, first_d;
    kstate_t             prev_q, prev_d, acc_q, acc_d, cand;
    logic [CODE_W-1:0]   prev_code_q, prev_code_d, cand_code;
    logic [STB_W-1:0]    stable_q, stable_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                valid_q, valid_d, press_q, press_d;
    logic                release_q, release_d, multi_q, multi_d;

    logic [1:0]          n_col, n_tot;
    logic [2:0]          sum;
    logic [ROW_W-1:0]    low_row;
    logic [CODE_W-1:0]   col_code, first_tot;

    assign kp.Columns    = ~(NUM_COLS'(1) << col_q);
    assign kp.KeyCode    = code_q;
    assign kp.KeyValid   = valid_q;
    assign kp.KeyPress   = press_q;
    assign kp.KeyRelease = release_q;
    assign kp.MultiKey   = multi_q;

    always_comb begin
        cnt_d       = cnt_q;
        col_d       = col_q;
        nacc_d      = nacc_q;
        first_d     = first_q;
        prev_d      = prev_q;
        prev_code_d = prev_code_q;
        stable_d    = stable_q;
        acc_d       = acc_q;
        code_d      = code_q;
        valid_d     = valid_q;
        multi_d     = multi_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        cand        = S_NONE;
        cand_code   = '0;

        // Contacts on the current column; descending loop leaves the lowest row.
        n_col   = 2'd0;
        low_row = '0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (!rows_s2[r]) begin
                low_row = ROW_W'(r);
                if (n_col != 2'd2) n_col = n_col + 2'd1;
            end
        end
        col_code  = CODE_W'(int'(low_row) * NUM_COLS + int'(col_q));
        sum       = {1'b0, nacc_q} + {1'b0, n_col};
        n_tot     = (sum >= 3'd2) ? 2'd2 : sum[1:0];
        // Columns are visited in ascending order, so the first one with a
        // contact owns the frame's reported code.
        first_tot = (nacc_q == 2'd0) ? col_code : first_q;

        if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            col_d = (col_q == COL_W'(NUM_COLS - 1)) ? '0 : col_q + COL_W'(1);
            if (col_q == COL_W'(NUM_COLS - 1)) begin
                // End of sweep: classify, debounce, maybe accept.
                cand = (n_tot == 2'd0) ? S_NONE : (n_tot == 2'd1) ? S_KEY : S_MULTI;
                if (cand == S_KEY) cand_code = first_tot;
                if (cand == prev_q && cand_code == prev_code_q)
                    stable_d = (stable_q == STB_W'(DEBOUNCE)) ? stable_q : stable_q + STB_W'(1);
                else
                    stable_d = STB_W'(1);
                prev_d      = cand;
                prev_code_d = cand_code;
                nacc_d      = 2'd0;
                first_d     = '0;
                if (stable_d == STB_W'(DEBOUNCE) &&
                    (cand != acc_q || (cand == S_KEY && cand_code != code_q))) begin
                    acc_d     = cand;
                    release_d = (acc_q == S_KEY);
                    valid_d   = (cand == S_KEY);
                    multi_d   = (cand == S_MULTI);
                    if (cand == S_KEY) begin
                        press_d = 1'b1;
                        code_d  = cand_code;
                    end
                end
            end else begin
                nacc_d  = n_tot;
                first_d = first_tot;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt_q       <= '0;
            col_q       <= '0;
            rows_s1     <= '1;
            rows_s2     <= '1;
            nacc_q      <= 2'd0;
            first_q     <= '0;
            prev_q      <= S_NONE;
            prev_code_q <= '0;
            stable_q    <= '0;
            acc_q       <= S_NONE;
            code_q      <= '0;
            valid_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            multi_q     <= 1'b0;
        end else begin
            rows_s1     <= kp.Rows;
            rows_s2     <= rows_s1;
            cnt_q       <= cnt_d;
            col_q       <= col_d;
            nacc_q      <= nacc_d;
            first_q     <= first_d;
            prev_q      <= prev_d;
            prev_code_q <= prev_code_d;
            stable_q    <= stable_d;
            acc_q       <= acc_d;
            code_q      <= code_d;
            valid_q     <= valid_d;
            press_q     <= press_d;
            release_q   <= release_d;
            multi_q     <= multi_d;
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner (4x4, SCAN_DIV=4, DEBOUNCE=3).
// Stimulus changes the held keys at frame starts and pushes the expected
// event with the cycle it must appear in; a monitor pops on every strobe
// or MultiKey change.
module tb_keypad_scanner;
    localparam int NR = 4, NC = 4, SD = 4, DB = 3;
    localparam int F  = NC * SD;

    typedef struct {
        logic       press;
        logic       rel;
        logic [3:0] code;
        logic       valid;
        logic       multi;
        int         at;
    } evt_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] keys;
    logic [3:0]  rows_m;
    int          cyc;
    int          tests = 0;
    int          fails = 0;
    evt_t        q[$];

    always #5 clk = ~clk;

    keypad_if #(.NUM_ROWS(NR), .NUM_COLS(NC)) kp();

    keypad_scanner #(.NUM_ROWS(NR), .NUM_COLS(NC), .SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .Clock(clk),
        .Reset(rst),
        .kp   (kp)
    );

    // Keypad model: a held key pulls its row low while its column is driven.
    always_comb begin
        rows_m = 4'b1111;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                if (!kp.Columns[c] && keys[r*NC + c]) rows_m[r] = 1'b0;
    end
    assign kp.Rows = rows_m;

    // Cycles since reset release, matching the scanner's restart at column 0.
    always_ff @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;

    function automatic logic [11:0] outs();
        return {kp.Columns, kp.KeyCode, kp.KeyValid, kp.KeyPress, kp.KeyRelease, kp.MultiKey};
    endfunction

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, required %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Keys changed at a frame start are sampled in that frame; the third
    // identical frame is evaluated 3F cycles later and outputs show then.
    task automatic expect_evt(input logic p, input logic r, input logic [3:0] c,
                              input logic v, input logic m);
        evt_t e;
        e.press = p; e.rel = r; e.code = c; e.valid = v; e.multi = m;
        e.at = cyc + DB * F;
        q.push_back(e);
    endtask

    task automatic next_frame();
        do @(negedge clk); while (cyc % F != 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < (DB + 1) * F + 8) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d events pending after %0d cycles, required 0", q.size(), n);
            q.delete();
        end
    endtask

    task automatic step(input logic [15:0] k, input logic p, input logic r,
                        input logic [3:0] c, input logic v, input logic m);
        next_frame();
        keys = k;
        expect_evt(p, r, c, v, m);
        drain();
    endtask

    // Monitor
    initial begin
        logic       mk_prev;
        logic [7:0] got, want;
        evt_t       e;
        mk_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mk_prev = 1'b0;
            end else begin
                if (kp.KeyPress || kp.KeyRelease || kp.MultiKey != mk_prev) begin
                    got = {kp.KeyPress, kp.KeyRelease, kp.KeyCode, kp.KeyValid, kp.MultiKey};
                    tests++;
                    if (q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_event: got p/r/code/v/m=%b at cycle %0d, required no event", got, cyc);
                    end else begin
                        e = q.pop_front();
                        want = {e.press, e.rel, e.code, e.valid, e.multi};
                        if (got !== want || cyc != e.at) begin
                            fails++;
                            $display("FAIL key_event: got p/r/code/v/m=%b at cycle %0d, required %b at cycle %0d",
                                     got, cyc, want, e.at);
                        end
                    end
                end
                mk_prev = kp.MultiKey;
            end
        end
    end

    initial begin
        logic [3:0] one;
        one  = 4'b0001;
        rst  = 1'b1;
        keys = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", outs(), {4'b1110, 8'h00});
        rst = 1'b0;

        // 1: idle scan, columns walk and wrap, outputs quiet
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) @(negedge clk);
            chk("idle_scan", outs(), {~(one << ((cyc / SD) % NC)), 8'h00});
        end

        // 2: row1/col2 press and release
        step(16'h0040, 1'b1, 1'b0, 4'd6, 1'b1, 1'b0);
        step(16'h0000, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0);

        // 3: bounce on alternate frames, then steady
        next_frame(); keys = 16'h0040;
        next_frame(); keys = 16'h0000;
        next_frame(); keys = 16'h0040;
        next_frame(); keys = 16'h0000;
        step(16'h0040, 1'b1, 1'b0, 4'd6, 1'b1, 1'b0);
        step(16'h0000, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0);

        // 4: two contacts -> MultiKey, release without strobes
        step(16'h8001, 1'b0, 1'b0, 4'd6, 1'b0, 1'b1);
        step(16'h0000, 1'b0, 1'b0, 4'd6, 1'b0, 1'b0);

        // 5: key-to-key, key-to-multi, multi-to-key, release
        step(16'h0040, 1'b1, 1'b0, 4'd6, 1'b1, 1'b0);
        step(16'h0200, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0);
        step(16'h0201, 1'b0, 1'b1, 4'd9, 1'b0, 1'b1);
        step(16'h0200, 1'b1, 1'b0, 4'd9, 1'b1, 1'b0);
        step(16'h0000, 1'b0, 1'b1, 4'd9, 1'b0, 1'b0);

        // 6: reset after two stable frames of key 6, key kept held
        next_frame(); keys = 16'h0040;
        next_frame();
        next_frame();
        rst = 1'b1;
        #1;
        chk("mid_debounce_reset", outs(), {4'b1110, 8'h00});
        @(negedge clk);
        chk("reset_hold", outs(), {4'b1110, 8'h00});
        @(negedge clk);
        rst = 1'b0;
        expect_evt(1'b1, 1'b0, 4'd6, 1'b1, 1'b0);
        drain();
        step(16'h0000, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0);

        repeat (F) @(negedge clk);
        chk("queue_empty", 12'(q.size()), 12'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
